// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: FSM encoding, wait-state limit and one-hot helper shared by the RAM bank array
package wb_ram_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam int MAX_WAIT_STATES = 7;

    function automatic logic one_hot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/wb_ram_bank_array_if.sv
// wb_ram_bank_array_if: Wishbone bus bundle between the bridge (master) and the RAM bank array (slave)
interface wb_ram_bank_array_if #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   WBs_ADR_i;
    logic [NUM_BANKS-1:0]    WBs_CYC_i;
    logic [DATA_WIDTH/8-1:0] WBs_BYTE_STB_i;
    logic                    WBs_WE_i;
    logic                    WBs_STB_i;
    logic [DATA_WIDTH-1:0]   WBs_DAT_i;
    logic [DATA_WIDTH-1:0]   WBs_DAT_o;
    logic                    WBs_ACK_o;
    logic                    WBs_ERR_o;
    logic                    Init_Busy_o;

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        input  WBs_DAT_o, WBs_ACK_o, WBs_ERR_o, Init_Busy_o
    );

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        output WBs_DAT_o, WBs_ACK_o, WBs_ERR_o, Init_Busy_o
    );
endinterface

// File: rtl/wb_ram_bank_mem.sv
// wb_ram_bank_mem: one DEPTH x DATA_WIDTH RAM bank with per-lane writes and a one-cycle synchronous read
module wb_ram_bank_mem #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < DATA_WIDTH/8; l++)
            if (i_we && i_be[l]) r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/wb_ram_bank_array.sv
// wb_ram_bank_array: Wishbone slave over NUM_BANKS RAM banks with byte lanes, read wait states and error on multi-bank select.
// Defining WB_RAM_INIT_CLEAR_EN adds a post-reset INIT pass that zeroes every bank.
module wb_ram_bank_array
    import wb_ram_pkg::*;
#(
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input logic                WBs_CLK_i,
    input logic                WBs_RST_i,
    wb_ram_bank_array_if.slave bus
);
    localparam int WS = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                r_state, w_next;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr, w_addr, w_init_addr;
    logic [NUM_BANKS-1:0]  r_cyc;
    logic [DATA_WIDTH-1:0] r_dat, w_rd_mux;
    logic [DATA_WIDTH-1:0] w_rdata [NUM_BANKS];
    logic                  r_ack, r_err;
    logic                  w_init, w_init_done, w_valid, w_onehot, w_accept, w_wr, w_rd;

`ifdef WB_RAM_INIT_CLEAR_EN
    localparam state_t RST_STATE = INIT;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    always_ff @(posedge WBs_CLK_i)
        r_init_addr <= (!WBs_RST_i || r_state != INIT) ? '0 : r_init_addr + 1'b1;
    assign w_init_addr = r_init_addr;
    assign w_init      = r_state == INIT;
    assign w_init_done = r_init_addr == LAST_ADDR;
`else
    localparam state_t RST_STATE = IDLE;
    assign w_init_addr = '0;
    assign w_init      = 1'b0;
    assign w_init_done = 1'b1;
`endif

    assign w_valid  = bus.WBs_STB_i && |bus.WBs_CYC_i;
    assign w_onehot = one_hot(8'(bus.WBs_CYC_i));

    always_ff @(posedge WBs_CLK_i)
        r_state <= WBs_RST_i ? w_next : RST_STATE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:    w_next = w_init_done ? IDLE : INIT;
            IDLE:    w_next = !w_valid ? IDLE : (!w_onehot || bus.WBs_WE_i) ? RESP : (WS > 0) ? RD_WAIT : RD_DATA;
            RD_WAIT: w_next = (r_cnt == '0) ? RD_DATA : RD_WAIT;
            RD_DATA: w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // Address is held in r_adr after accept so the bank keeps presenting the read word through the wait states
    always_comb begin
        w_accept = r_state == IDLE && w_valid && WBs_RST_i;
        w_wr     = w_accept && w_onehot && bus.WBs_WE_i;
        w_rd     = w_accept && w_onehot && !bus.WBs_WE_i;
        w_addr   = w_init ? w_init_addr : (r_state == IDLE) ? bus.WBs_ADR_i : r_adr;
        w_rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) w_rd_mux = r_cyc[b] ? w_rdata[b] : w_rd_mux;
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_cnt <= '0;
            r_adr <= '0;
            r_cyc <= '0;
        end else begin
            r_ack <= w_wr || r_state == RD_DATA;
            r_err <= w_accept && !w_onehot;
            r_dat <= (r_state == RD_DATA) ? w_rd_mux : r_dat;
            r_cnt <= w_rd ? 3'(WS - 1) : (r_state == RD_WAIT && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
            r_adr <= w_accept ? bus.WBs_ADR_i : r_adr;
            r_cyc <= w_accept ? bus.WBs_CYC_i : r_cyc;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        wb_ram_bank_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
            .i_clk   (WBs_CLK_i),
            .i_we    (WBs_RST_i && (w_init || (w_wr && bus.WBs_CYC_i[b]))),
            .i_addr  (w_addr),
            .i_be    (w_init ? '1 : bus.WBs_BYTE_STB_i),
            .i_wdata (w_init ? '0 : bus.WBs_DAT_i),
            .o_rdata (w_rdata[b])
        );
    end

    assign bus.WBs_ACK_o   = r_ack;
    assign bus.WBs_ERR_o   = r_err;
    assign bus.WBs_DAT_o   = r_dat;
    assign bus.Init_Busy_o = w_init;
endmodule

// File: tb/tb_wb_ram_bank_array.sv
// tb_wb_ram_bank_array: directed checks of a zero-wait and a three-wait-state bank array driven with identical traffic
module tb_wb_ram_bank_array;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, we;
    logic [3:0]  cyc, be;
    logic [8:0]  adr;
    logic [31:0] dat;
    int          n_chk = 0, n_pass = 0, n_fail = 0, n_init = 0;

    always #5 clk = ~clk;

    wb_ram_bank_array_if #(.NUM_BANKS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32)) b0 ();
    wb_ram_bank_array_if #(.NUM_BANKS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32)) b3 ();

    assign b0.WBs_STB_i = stb;  assign b3.WBs_STB_i = stb;
    assign b0.WBs_WE_i  = we;   assign b3.WBs_WE_i  = we;
    assign b0.WBs_CYC_i = cyc;  assign b3.WBs_CYC_i = cyc;
    assign b0.WBs_ADR_i = adr;  assign b3.WBs_ADR_i = adr;
    assign b0.WBs_DAT_i = dat;  assign b3.WBs_DAT_i = dat;
    assign b0.WBs_BYTE_STB_i = be;  assign b3.WBs_BYTE_STB_i = be;

    wb_ram_bank_array #(.NUM_BANKS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst_n),
        .bus       (b0)
    );

    wb_ram_bank_array #(.NUM_BANKS(4), .ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst_n),
        .bus       (b3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic w, input logic [3:0] c, input logic [3:0] b,
                         input logic [8:0] a, input logic [31:0] d);
        stb = s; we = w; cyc = c; be = b; adr = a; dat = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 9'h0, 32'h0);
    endtask

    // Write: ACK during cycle 1 on both instances, gone in cycle 2
    task automatic wr(input logic [3:0] c, input logic [8:0] a, input logic [31:0] d,
                      input logic [3:0] b, input string tag);
        drive(1'b1, 1'b1, c, b, a, d);
        step();
        idle();
        chk1({tag, ".ack"}, b0.WBs_ACK_o, 1'b1);
        chk1({tag, ".err"}, b0.WBs_ERR_o, 1'b0);
        chk1({tag, ".ack3"}, b3.WBs_ACK_o, 1'b1);
        step();
        chk1({tag, ".ack_once"}, b0.WBs_ACK_o, 1'b0);
    endtask

    // Read: zero-wait ACK at cycle 2, three-wait ACK at cycle 5, data held afterwards
    task automatic rd(input logic [3:0] c, input logic [8:0] a, input logic [31:0] exp, input string tag);
        drive(1'b1, 1'b0, c, 4'hF, a, 32'h0);
        step();
        idle();
        for (int k = 1; k <= 6; k++) begin
            chk1($sformatf("%s.ack@%0d", tag, k), b0.WBs_ACK_o, k == 2);
            chk1($sformatf("%s.ack3@%0d", tag, k), b3.WBs_ACK_o, k == 5);
            if (k == 2) chk({tag, ".dat"}, b0.WBs_DAT_o, exp);
            if (k >= 5) chk($sformatf("%s.dat3@%0d", tag, k), b3.WBs_DAT_o, exp);
            if (k < 6) step();
        end
    endtask

    task automatic err(input logic [3:0] c, input logic [8:0] a, input logic [31:0] d,
                       input logic [31:0] held, input string tag);
        drive(1'b1, 1'b1, c, 4'hF, a, d);
        step();
        idle();
        chk1({tag, ".err"}, b0.WBs_ERR_o, 1'b1);
        chk1({tag, ".ack"}, b0.WBs_ACK_o, 1'b0);
        chk1({tag, ".err3"}, b3.WBs_ERR_o, 1'b1);
        chk({tag, ".dat_held"}, b0.WBs_DAT_o, held);
        step();
        chk1({tag, ".err_once"}, b0.WBs_ERR_o, 1'b0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (b0.Init_Busy_o && n < 2000) begin
            n++;
            step();
        end
        chk1("init_done", b0.Init_Busy_o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        chk1("rst.ack", b0.WBs_ACK_o, 1'b0);
        chk1("rst.err", b0.WBs_ERR_o, 1'b0);
        chk("rst.dat", b0.WBs_DAT_o, 32'h0);
        chk("rst.dat3", b3.WBs_DAT_o, 32'h0);
`ifdef WB_RAM_INIT_CLEAR_EN
        chk1("rst.busy", b0.Init_Busy_o, 1'b1);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'b0001, 4'hF, 9'd7, 32'h0);
        wait_init(n_init);
        chk("init.cycles", n_init, 32'd512);
        rd(4'b0001, 9'd7, 32'h0, "init_rd");
`else
        chk1("rst.busy", b0.Init_Busy_o, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("busy_tied", b0.Init_Busy_o, 1'b0);
`endif
        wr(4'b0001, 9'h1F3, 32'h1111_1111, 4'hF, "w_b0");
        wr(4'b0010, 9'h1F3, 32'h2222_2222, 4'hF, "w_b1");
        wr(4'b1000, 9'h1F3, 32'h3333_3333, 4'hF, "w_b3");
        wr(4'b0100, 9'h1F3, 32'hA5A5_1234, 4'hF, "w_b2");
        rd(4'b0100, 9'h1F3, 32'hA5A5_1234, "r_b2");
        rd(4'b0001, 9'h1F3, 32'h1111_1111, "r_b0");
        rd(4'b0010, 9'h1F3, 32'h2222_2222, "r_b1");
        rd(4'b1000, 9'h1F3, 32'h3333_3333, "r_b3");
        wr(4'b0001, 9'd5, 32'hFFFF_FFFF, 4'hF, "w_ones");
        wr(4'b0001, 9'd5, 32'h0000_0000, 4'b0101, "w_lanes");
        rd(4'b0001, 9'd5, 32'hFF00_FF00, "r_lanes");
        wr(4'b0001, 9'd5, 32'h1234_5678, 4'b0000, "w_be0");
        rd(4'b0001, 9'd5, 32'hFF00_FF00, "r_be0");
        err(4'b0110, 9'h1F3, 32'hDEAD_BEEF, 32'hFF00_FF00, "err");
        rd(4'b0010, 9'h1F3, 32'h2222_2222, "r_err_b1");
        rd(4'b0100, 9'h1F3, 32'hA5A5_1234, "r_err_b2");
        drive(1'b1, 1'b0, 4'b0000, 4'hF, 9'h1F3, 32'h0);
        step();
        step();
        chk1("nocyc.ack", b0.WBs_ACK_o, 1'b0);
        chk1("nocyc.err", b0.WBs_ERR_o, 1'b0);
        drive(1'b0, 1'b0, 4'b0100, 4'hF, 9'h1F3, 32'h0);
        step();
        step();
        chk1("nostb.ack", b0.WBs_ACK_o, 1'b0);
        chk1("nostb.ack3", b3.WBs_ACK_o, 1'b0);
        chk("nostb.dat", b0.WBs_DAT_o, 32'hA5A5_1234);
        idle();
        // Reset one edge after a read is accepted: the pending ACK must never appear
        drive(1'b1, 1'b0, 4'b0001, 4'hF, 9'd5, 32'h0);
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("mid.ack", b0.WBs_ACK_o, 1'b0);
        chk("mid.dat", b0.WBs_DAT_o, 32'h0);
        step();
        chk1("mid.ack_later", b0.WBs_ACK_o, 1'b0);
`ifdef WB_RAM_INIT_CLEAR_EN
        wait_init(n_init);
`endif
        drive(1'b1, 1'b1, 4'b0010, 4'hF, 9'h1F3, 32'h0BAD_F00D);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        chk1("rstw.ack", b0.WBs_ACK_o, 1'b0);
        chk1("rstw.err", b0.WBs_ERR_o, 1'b0);
        chk("rstw.dat", b0.WBs_DAT_o, 32'h0);
        chk("rstw.dat3", b3.WBs_DAT_o, 32'h0);
        step();
        chk1("rstw.ack_later", b0.WBs_ACK_o, 1'b0);
`ifdef WB_RAM_INIT_CLEAR_EN
        wait_init(n_init);
        rd(4'b0010, 9'h1F3, 32'h0, "r_rstw");
`else
        rd(4'b0010, 9'h1F3, 32'h2222_2222, "r_rstw");
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_ram_bank_array.md
# wb_ram_bank_array

Parametrised Wishbone slave that exposes NUM_BANKS independent on-chip RAM banks behind the AHB-to-FPGA bridge, one bank selected per cycle by a one-hot cycle vector. Generalises the fixed four-bank 512x32 RAM block:
- configurable width, depth and bank count;
- honoured byte lanes;
- programmable read wait states;
- a single muxed read-data bus;
- error response on illegal bank selection;
- optional post-reset memory clear.

## Interface
- NUM_BANKS, 4: number of RAM banks (1..8)
- ADDR_WIDTH, 9: word address width per bank; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 32: data width, multiple of 8; LANES = DATA_WIDTH/8
- WAIT_STATES, 0: extra read cycles before ACK (0..7)

Ports:
- WBs_CLK_i  in  1  FPGA clock; all logic on rising edge
- WBs_RST_i  in  1  reset; synchronous, active-low (asserted when 0)
- WBs_ADR_i  in  ADDR_WIDTH  word address within selected bank
- WBs_CYC_i  in  NUM_BANKS  one-hot bank cycle select
- WBs_BYTE_STB_i  in  LANES  byte-lane write enables
- WBs_WE_i  in  1  1 = write, 0 = read
- WBs_STB_i  in  1  transfer strobe
- WBs_DAT_i  in  DATA_WIDTH  write data
- WBs_DAT_o  out  DATA_WIDTH  registered read data; holds last read value
- WBs_ACK_o  out  1  one-cycle transfer acknowledge
- WBs_ERR_o  out  1  one-cycle error acknowledge
- Init_Busy_o  out  1  memory clear in progress

## Operation
- FSM states: INIT, IDLE, RD_WAIT, RD_DATA, RESP.
- Request valid in IDLE when WBs_STB_i=1 and WBs_CYC_i nonzero.
- Exactly one CYC bit, write:
  - On the accept edge, write WBs_DAT_i to the selected bank at WBs_ADR_i, lanes gated by WBs_BYTE_STB_i.
  - Other banks are untouched.
  - Go to RESP with ACK.
- Exactly one CYC bit, read:
  - Issue bank read on the accept edge.
  - Go to RD_WAIT if WAIT_STATES>0 (counter loads WAIT_STATES-1, decrements to 0), else RD_DATA.
  - RD_DATA registers the selected bank output into WBs_DAT_o and goes to RESP with ACK.
- More than one CYC bit: no memory access, WBs_DAT_o unchanged, go to RESP with ERR.
- CYC all zero, or STB=0: stay in IDLE.
- RESP: ACK or ERR high for exactly one cycle, then return to IDLE. A new request is accepted no earlier than the cycle after RESP.
- WBs_BYTE_STB_i=0 on a write still ACKs and changes nothing.

## Timing
- Reset values: WBs_ACK_o=0, WBs_ERR_o=0, WBs_DAT_o=0, counter=0.
- State after reset: INIT with macro, IDLE without.
- Write: STB accepted at edge 0, ACK high during cycle 1.
- Read: ACK and valid WBs_DAT_o during cycle 2+WAIT_STATES.
- Error: ERR high during cycle 1.
- Reset wins over any same-edge access: no write performed, no ACK/ERR.
- Reset mid-transaction aborts: outputs return to reset values at the next edge.
- Back-to-back read after write to the same address returns the new data.
- ACK and ERR are never high together.

## Configuration
- WB_RAM_INIT_CLEAR_EN defined:
  - After reset release, INIT writes zero to every address of every bank, one address per cycle (DEPTH cycles), with Init_Busy_o=1.
  - Then IDLE, Init_Busy_o=0.
  - Requests arriving during INIT are held without response and accepted in the first IDLE cycle.
- Macro undefined:
  - No INIT state; Init_Busy_o tied 0.
  - Memory contents after power-up are undefined.

## Structure
- Shared package/include wb_ram_pkg:
  - FSM state encodings;
  - WAIT_STATES range limit;
  - helper function for the one-hot check (popcount == 1).
- Sub-module wb_ram_bank_mem:
  - one bank, DEPTH x DATA_WIDTH;
  - synchronous one-cycle read;
  - per-lane write enables;
  - instantiated NUM_BANKS times by generate.
- Top-level contains the FSM, wait counter, INIT address counter, read mux and response registers.

## Test plan
- Write 0xA5A5_1234 to bank 2 addr 0x1F3 with BYTE_STB=4'hF, then read it back -> ACK at cycle 1 for the write; ACK at cycle 2 for the read with WBs_DAT_o=0xA5A5_1234; same address in banks 0, 1, 3 unchanged.
- Write 0xFFFF_FFFF to bank 0 addr 5, then 0x0000_0000 with BYTE_STB=4'b0101 -> readback 0xFF00_FF00.
- WAIT_STATES=3, read bank 1 -> ACK exactly at cycle 5; WBs_DAT_o stable from that cycle until the next read.
- WBs_CYC_i=4'b0110 with write 0xDEAD_BEEF -> ERR high for one cycle at cycle 1, no ACK; both banks keep prior contents; WBs_DAT_o unchanged.
- Assert reset on the accept edge of a write -> no ACK; subsequent read of that address returns the old value, or 0 with the macro.
- With WB_RAM_INIT_CLEAR_EN, ADDR_WIDTH=9: issue a read during INIT -> Init_Busy_o high for 512 cycles; the read is ACKed 2 cycles after INIT ends with data 0.
